service_scheduler: RTL and testbench

Mode controller that owns the shared front-panel resources (4-digit 7-segment data bus, digit-select mask, service LEDs, push-button events) and grants them to exactly one of the four services at a time. It decodes the four service switches, enables the selected service, and muxes that service's display word onto the segment driver. It retires a service on its finish pulse and lets the alarm-check service (service 4) pre-empt any other owner. It sits between the switch/button inputs and the service modules, replacing the shared `num` net and the ad-hoc LED logic in the top level.

---
 rtl/service_scheduler_pkg.sv | 35 +++
 rtl/service_scheduler_push_edge.sv | 26 ++
 rtl/service_scheduler.sv | 143 ++++++++++++++
 tb/tb_service_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/service_scheduler_pkg.sv
// Shared constants for the front-panel service scheduler: one-hot service codes,
// FSM encoding and push-button layout. No logic, no latency, no backpressure.
package service_scheduler_pkg;

    localparam int NUM_W_DEF = 16;

    localparam logic [3:0] SERVICE1     = 4'b1000;
    localparam logic [3:0] SERVICE2     = 4'b0100;
    localparam logic [3:0] SERVICE3     = 4'b0010;
    localparam logic [3:0] SERVICE4     = 4'b0001;
    localparam logic [3:0] SERVICERESET = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    // Button layout, bit4..bit0.
    typedef struct packed {
        logic m;
        logic r;
        logic l;
        logic d;
        logic u;
    } push_t;

    localparam int PUSH_W = $bits(push_t);

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/service_scheduler_push_edge.sv
// Rising-edge pulses for the buttons, emitted only while the grant gate is open.
// One-cycle registered latency; no backpressure, events are dropped when gated.
module push_edge_detect
    import service_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [PUSH_W-1:0] push,
    input  logic              gate,
    output logic [PUSH_W-1:0] push_evt
);

    logic [PUSH_W-1:0] push_q;

    // All-ones after reset so a button held through reset never looks like a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q   <= '1;
            push_evt <= '0;
        end else begin
            push_q   <= push;
            push_evt <= gate ? (push & ~push_q) : '0;
        end
    end

endmodule

// File: rtl/service_scheduler.sv
// Grants the front-panel display, LEDs and buttons to one service at a time; alarm pre-empts.
// Grant is registered (1 cycle after switches), display mux follows the grant combinationally.
module service_scheduler
    import service_scheduler_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           spdt_service,
    input  logic [3:0]           finish,
    input  logic                 alarm_hit,
    input  logic [4:0]           push,
    input  logic [4*NUM_W-1:0]   num_in,
    input  logic [15:0]          sel_in,
    input  logic [NUM_W-1:0]     current_time,
    output logic [3:0]           svc_en,
    output logic [4:0]           push_evt,
    output logic [NUM_W-1:0]     num_out,
    output logic [3:0]           sel_out,
    output logic [3:0]           spdt_led,
    output logic [1:0]           state,
    output logic                 err
);

    state_t     cur_state, nxt_state;
    logic [3:0] owner, nxt_owner;
    logic       nxt_err;
    logic       grant_next;
    logic [3:0] disp_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            owner     <= SERVICERESET;
            err       <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            owner     <= nxt_owner;
            err       <= nxt_err;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        nxt_owner = owner;
        nxt_err   = 1'b0;
        unique case (cur_state)
            ST_IDLE: begin
                if (alarm_hit) begin
                    nxt_state = ST_ALARM;
                    nxt_owner = SERVICE4;
                end else if (is_one_hot(spdt_service)) begin
                    nxt_state = ST_ACTIVE;
                    nxt_owner = spdt_service;
                end else begin
                    nxt_err = (spdt_service != SERVICERESET);
                end
            end
            ST_ACTIVE: begin
                // The pre-empted owner is dropped; it must be re-selected from IDLE.
                if (alarm_hit && (owner != SERVICE4)) begin
                    nxt_state = ST_ALARM;
                    nxt_owner = SERVICE4;
                end else if ((finish & owner) != 4'b0000) begin
                    nxt_state = ST_DONE;
                end else if (spdt_service != owner) begin
                    nxt_state = ST_IDLE;
                    nxt_owner = SERVICERESET;
                end
            end
            ST_DONE: begin
                if (alarm_hit) begin
                    nxt_state = ST_ALARM;
                    nxt_owner = SERVICE4;
                end else if (spdt_service == SERVICERESET) begin
                    nxt_state = ST_IDLE;
                    nxt_owner = SERVICERESET;
                end
            end
            ST_ALARM: begin
                if (finish[0]) begin
                    nxt_state = ST_DONE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_owner = SERVICERESET;
            end
        endcase
    end

    assign grant_next = (nxt_state == ST_ACTIVE) || (nxt_state == ST_ALARM);

    push_edge_detect u_push_edge (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .gate     (grant_next),
        .push_evt (push_evt)
    );

    always_comb begin
        disp_owner = SERVICERESET;
        if (cur_state == ST_ACTIVE) begin
            disp_owner = owner;
        end else if (cur_state == ST_ALARM) begin
            disp_owner = SERVICE4;
        end
    end

    always_comb begin
        num_out = current_time;
        sel_out = 4'b0000;
        case (disp_owner)
            SERVICE1: begin
                num_out = num_in[4*NUM_W-1 -: NUM_W];
                sel_out = sel_in[15:12];
            end
            SERVICE2: begin
                num_out = num_in[3*NUM_W-1 -: NUM_W];
                sel_out = sel_in[11:8];
            end
            SERVICE3: begin
                num_out = num_in[2*NUM_W-1 -: NUM_W];
                sel_out = sel_in[7:4];
            end
            SERVICE4: begin
                num_out = num_in[NUM_W-1:0];
                sel_out = sel_in[3:0];
            end
            default: begin
                num_out = current_time;
                sel_out = 4'b0000;
            end
        endcase
    end

    assign svc_en   = disp_owner;
    assign spdt_led = disp_owner;
    assign state    = cur_state;

endmodule

// File: tb/tb_service_scheduler.sv
// Directed plus randomized bench for service_scheduler against a service-number level model.
module tb_service_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  spdt_service;
    logic [3:0]  finish;
    logic        alarm_hit;
    logic [4:0]  push;
    logic [63:0] num_in;
    logic [15:0] sel_in;
    logic [15:0] current_time;
    logic [3:0]  svc_en;
    logic [4:0]  push_evt;
    logic [15:0] num_out;
    logic [3:0]  sel_out;
    logic [3:0]  spdt_led;
    logic [1:0]  state;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 idle, 1 granted, 2 waiting for switches down, 3 alarm; who = service 1..4.
    int         m_mode;
    int         m_who;
    logic       m_err;
    logic [4:0] m_evt;
    logic [4:0] m_prev_push;

    service_scheduler #(.NUM_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .spdt_service (spdt_service),
        .finish       (finish),
        .alarm_hit    (alarm_hit),
        .push         (push),
        .num_in       (num_in),
        .sel_in       (sel_in),
        .current_time (current_time),
        .svc_en       (svc_en),
        .push_evt     (push_evt),
        .num_out      (num_out),
        .sel_out      (sel_out),
        .spdt_led     (spdt_led),
        .state        (state),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] code_of(input int s);
        return 4'(1 << (4 - s));
    endfunction

    function automatic int service_of(input logic [3:0] sw);
        for (int s = 1; s <= 4; s++) begin
            if (sw == code_of(s)) return s;
        end
        return 0;
    endfunction

    task automatic model_edge();
        int nm;
        nm = m_mode;
        if (reset) begin
            m_mode = 0; m_who = 0; m_err = 1'b0; m_evt = 5'd0; m_prev_push = 5'b11111;
            return;
        end
        case (m_mode)
            0: if (alarm_hit) begin nm = 3; m_who = 4; end
               else if (service_of(spdt_service) != 0) begin nm = 1; m_who = service_of(spdt_service); end
            1: if (alarm_hit && m_who != 4) begin nm = 3; m_who = 4; end
               else if (finish[4 - m_who]) nm = 2;
               else if (spdt_service != code_of(m_who)) nm = 0;
            2: if (alarm_hit) begin nm = 3; m_who = 4; end
               else if (spdt_service == 4'd0) nm = 0;
            default: if (finish[0]) nm = 2;
        endcase
        m_err       = (m_mode == 0) && !alarm_hit && ($countones(spdt_service) > 1);
        m_evt       = (nm == 1 || nm == 3) ? (push & ~m_prev_push) : 5'd0;
        m_prev_push = push;
        m_mode      = nm;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int         disp;
        logic [3:0] e_en;
        logic [15:0] e_num;
        logic [3:0] e_sel;
        disp  = (m_mode == 1) ? m_who : (m_mode == 3) ? 4 : 0;
        e_en  = (disp == 0) ? 4'd0 : code_of(disp);
        e_num = (disp == 0) ? current_time : num_in[(4 - disp) * 16 +: 16];
        e_sel = (disp == 0) ? 4'd0 : sel_in[(4 - disp) * 4 +: 4];
        chk("state",    {14'd0, state},   16'(m_mode));
        chk("svc_en",   {12'd0, svc_en},  {12'd0, e_en});
        chk("spdt_led", {12'd0, spdt_led}, {12'd0, e_en});
        chk("err",      {15'd0, err},     {15'd0, m_err});
        chk("push_evt", {11'd0, push_evt}, {11'd0, m_evt});
        chk("num_out",  num_out,          e_num);
        chk("sel_out",  {12'd0, sel_out}, {12'd0, e_sel});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; spdt_service = 4'd0; finish = 4'd0; alarm_hit = 1'b0; push = 5'd0;
        num_in = 64'h1111_2222_3333_4444; sel_in = 16'h8421; current_time = 16'h1234;
        m_mode = 0; m_who = 0; m_err = 1'b0; m_evt = 5'd0; m_prev_push = 5'b11111;
        #2;
        step(); step();
        reset = 1'b0; step();

        // Grant service 2, then swap to service 1 (abort through IDLE)
        spdt_service = 4'b0100; step(); step();
        spdt_service = 4'b1000; step(); step();

        // Button press while granted: one event
        push = 5'b00001; step(); step(); step();
        push = 5'b00000; step();

        // Finish with switch still up: DONE holds until switch down
        finish = 4'b1000; step();
        finish = 4'b0000; repeat (5) step();
        spdt_service = 4'b0000; step(); step();

        // Press in IDLE: no event
        push = 5'b00001; step(); step();
        push = 5'b00000; step();

        // Alarm and finish together pre-empt service 3
        spdt_service = 4'b0010; step(); step();
        alarm_hit = 1'b1; finish = 4'b0010; step();
        alarm_hit = 1'b0; finish = 4'b0000; spdt_service = 4'b1000; step(); step();
        finish = 4'b0001; step();
        finish = 4'b0000; spdt_service = 4'b0000; step(); step();

        // Multi-hot switches flag err, then resolve
        spdt_service = 4'b1100; step(); step();
        spdt_service = 4'b1000; step(); step();
        spdt_service = 4'b0000; step(); step();

        // Button held across reset while service 4 selected
        spdt_service = 4'b0001; push = 5'b00100; step(); step();
        reset = 1'b1; step();
        reset = 1'b0; step(); step(); step();
        push = 5'b00000; step();
        push = 5'b00100; step(); step();
        push = 5'b00000; spdt_service = 4'b0000; step(); step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                int r;
                r = $urandom_range(9);
                if (r < 4)      spdt_service = code_of(r + 1);
                else if (r < 7) spdt_service = 4'd0;
                else            spdt_service = 4'($urandom);
            end
            finish       = ($urandom_range(5) == 0) ? 4'($urandom) : 4'd0;
            alarm_hit    = ($urandom_range(30) == 0);
            if ($urandom_range(3) == 0) push = 5'($urandom);
            reset        = ($urandom_range(200) == 0);
            num_in       = {$urandom, $urandom};
            sel_in       = 16'($urandom);
            current_time = 16'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
